wb_uart_lite: RTL



---
 rtl/wb_uart_lite_pkg.sv | 34 +++
 rtl/uart_sync_fifo.sv | 45 ++++
 rtl/wb_uart_lite.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_lite_pkg.sv
// Shared register map, status/control layouts and FSM encodings for wb_uart_lite.
package wb_uart_lite_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int unsigned STAT_OVERRUN_BIT   = 3;
    localparam int unsigned STAT_FRAME_ERR_BIT = 4;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    typedef struct packed {
        logic frame_err;
        logic overrun;
        logic tx_idle;
        logic tx_full;
        logic rx_valid;
    } uart_status_t;

    typedef struct packed {
        logic tx_ie;
        logic rx_ie;
    } uart_ctrl_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read; pushes while full are dropped.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/wb_uart_lite.sv
// Wishbone slave 8N1 UART: register decode, TX FIFO + serialiser, RX deserialiser, interrupt.
module wb_uart_lite
    import wb_uart_lite_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 434,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        int_o
);

    localparam int unsigned         CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

    // Bus decode: one access per request cycle, acked on the following cycle.
    logic        bus_req;
    logic [1:0]  reg_sel;
    logic        wr_en;
    logic        tx_push;
    logic        stat_wr;
    logic        ctrl_wr;
    logic        data_rd;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign bus_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign reg_sel     = wb_adr_i[3:2];
    assign wr_en       = bus_req & wb_we_i & wb_sel_i[0];
    assign tx_push     = wr_en & (reg_sel == REG_DATA);
    assign stat_wr     = wr_en & (reg_sel == REG_STATUS);
    assign ctrl_wr     = wr_en & (reg_sel == REG_CTRL);
    assign data_rd     = bus_req & ~wb_we_i & (reg_sel == REG_DATA);
    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         overrun;
    logic         frame_err;
    uart_ctrl_t   ctrl;
    uart_status_t status;

    // TX FIFO and serialiser
    logic [7:0]       fifo_rd_data;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_pop;
    logic [1:0]       tx_state;
    logic [1:0]       tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [2:0]       tx_bit_nxt;
    logic [7:0]       tx_shift;
    logic             tx_line_nxt;
    logic             tx_tick;
    logic             tx_idle;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .push    (tx_push),
        .wr_data (wb_dat_i[7:0]),
        .pop     (tx_pop),
        .rd_data (fifo_rd_data),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign tx_tick = (tx_cnt == BIT_LAST);
    assign tx_idle = tx_empty & (tx_state == TX_IDLE);

    // STOP pops straight into START when more data waits, so frames run gap-free.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        tx_bit_nxt   = tx_bit;
        tx_line_nxt  = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_bit_nxt = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_pop       = 1'b1;
                        tx_state_nxt = TX_START;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        case (tx_state_nxt)
            TX_START: tx_line_nxt = 1'b0;
            TX_DATA:  tx_line_nxt = tx_shift[tx_bit_nxt];
            default:  tx_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_o     <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_o     <= tx_line_nxt;
            tx_cnt   <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + CNT_W'(1);
            if (tx_pop) tx_shift <= fifo_rd_data;
        end
    end

    // RX synchroniser, edge detect and deserialiser
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             rx_fall;
    logic [1:0]       rx_state;
    logic [1:0]       rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt;
    logic             rx_cnt_clr;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_shift_en;
    logic             rx_done;

    assign rx_fall = rx_prev & ~rx_sync;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_clr   = 1'b0;
        rx_shift_en  = 1'b0;
        rx_done      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_clr = 1'b1;
                if (rx_fall) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_clr   = 1'b1;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_clr  = 1'b1;
                    rx_shift_en = 1'b1;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_clr   = 1'b1;
                    rx_done      = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= rx_i;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_clr ? '0 : rx_cnt + CNT_W'(1);
            if (rx_shift_en) begin
                rx_bit   <= rx_bit + 3'd1;
                rx_shift <= {rx_sync, rx_shift[7:1]};
            end
        end
    end

    // Register file, read mux and interrupt
    assign status = {frame_err, overrun, tx_idle, tx_full, rx_valid};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA:   if (rx_valid) rd_data = {24'b0, rx_byte};
            REG_STATUS: rd_data = {27'b0, status};
            REG_CTRL:   rd_data = {30'b0, ctrl};
            default:    rd_data = '0;
        endcase
    end

    // A DATA read racing a new byte returns the old byte and does not count as overrun.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            ctrl      <= '0;
            int_o     <= 1'b0;
        end else begin
            wb_ack_o <= bus_req;
            if (bus_req) wb_dat_o <= wb_we_i ? 32'b0 : rd_data;
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end
            overrun   <= (overrun & ~(stat_wr & wb_dat_i[STAT_OVERRUN_BIT]))
                       | (rx_done & rx_valid & ~data_rd);
            frame_err <= (frame_err & ~(stat_wr & wb_dat_i[STAT_FRAME_ERR_BIT]))
                       | (rx_done & ~rx_sync);
            if (ctrl_wr) ctrl <= uart_ctrl_t'(wb_dat_i[1:0]);
            int_o <= (ctrl.rx_ie & rx_valid) | (ctrl.tx_ie & tx_idle);
        end
    end

endmodule
